// File: rtl/uram_event_write_sm.sv
// Write-side sequencer for the URAM event buffer: header write, 1536-word capture, buffer occupancy.
// Optional trigger holdoff after each capture is enabled with `define URAM_EVENT_WRITE_HOLDOFF_EN.
`default_nettype none

module uram_event_write_sm #(
  parameter int unsigned NBUF_BITS = 2,
  parameter int unsigned HOLDOFF   = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clk_ce_i,
  input  logic                   trig_i,
  input  logic [31:0]            trig_time_i,
  output logic                   header_wr_o,
  output logic [63:0]            header_dat_o,
  output logic                   wr_we_o,
  output logic [2:0]             wr_bram_en_o,
  output logic [8:0]             wr_bram_addr_o,
  output logic [NBUF_BITS-1:0]   wr_buf_o,
  output logic                   busy_o,
  output logic                   data_available_o,
  input  logic                   complete_i,
  output logic [NBUF_BITS:0]     buf_count_o,
  output logic                   dropped_o,
  output logic [15:0]            drop_count_o,
  output logic                   err_underflow_o
);

  localparam int unsigned NBUF   = 1 << NBUF_BITS;
  localparam int unsigned WORDS  = 1536;
  localparam int unsigned WORD_W = 11;
  localparam int unsigned CNT_W  = NBUF_BITS + 1;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CAPTURE = 1'b1;

  if (HOLDOFF < 1) begin : g_holdoff_check
    $error("HOLDOFF must be at least 1");
  end

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [WORD_W-1:0]    r_word;
  logic [31:0]          r_event_no;
  logic [NBUF_BITS-1:0] r_wr_ptr;
  logic                 r_commit;
  logic [CNT_W-1:0]     r_buf_count;
  logic                 r_header_wr;
  logic [63:0]          r_header_dat;
  logic                 r_dropped;
  logic [15:0]          r_drop_count;
  logic                 r_err_underflow;

  logic                 w_trig;
  logic                 w_busy;
  logic [CNT_W-1:0]     w_occupied;
  logic                 w_full;
  logic                 w_holdoff_busy;
  logic                 w_accept;
  logic                 w_reject;
  logic                 w_last;
  logic [2:0]           w_bram_en;

  assign w_trig  = clk_ce_i & trig_i;
  assign w_busy  = (r_state == ST_CAPTURE);
  // A commit still waiting to reach r_buf_count already owns its slot.
  assign w_occupied = r_buf_count + CNT_W'(r_commit);
  assign w_full     = (w_occupied >= CNT_W'(NBUF));
  assign w_accept   = (r_state == ST_IDLE) & w_trig & ~w_full & ~w_holdoff_busy;
  assign w_reject   = w_trig & ~w_accept;
  assign w_last     = w_busy & clk_ce_i & (r_word == WORD_W'(WORDS - 1));

`ifdef URAM_EVENT_WRITE_HOLDOFF_EN
  localparam int unsigned HO_W = $clog2(HOLDOFF + 1);
  logic [HO_W-1:0] r_holdoff;

  assign w_holdoff_busy = (r_holdoff != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_holdoff <= '0;
    end else if (w_last) begin
      r_holdoff <= HO_W'(HOLDOFF);
    end else if (clk_ce_i && w_holdoff_busy) begin
      r_holdoff <= r_holdoff - HO_W'(1);
    end
  end
`else
  assign w_holdoff_busy = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (w_last)   w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture word counter, header and write pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_word       <= '0;
      r_event_no   <= '0;
      r_wr_ptr     <= '0;
      r_commit     <= 1'b0;
      r_header_wr  <= 1'b0;
      r_header_dat <= '0;
    end else begin
      r_header_wr <= w_accept;
      r_commit    <= w_last;
      if (w_accept) begin
        r_header_dat <= {r_event_no, trig_time_i};
        r_event_no   <= r_event_no + 32'd1;
        r_word       <= '0;
      end else if (w_last) begin
        r_word   <= '0;
        r_wr_ptr <= r_wr_ptr + NBUF_BITS'(1);
      end else if (w_busy && clk_ce_i) begin
        r_word <= r_word + WORD_W'(1);
      end
    end
  end

  // Occupancy, drop accounting and underflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_buf_count     <= '0;
      r_dropped       <= 1'b0;
      r_drop_count    <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_dropped <= w_reject;
      if (w_reject && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      case ({r_commit, complete_i})
        2'b10: r_buf_count <= r_buf_count + CNT_W'(1);
        2'b01: begin
          if (r_buf_count != '0) begin
            r_buf_count <= r_buf_count - CNT_W'(1);
          end else begin
            r_err_underflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_bram_en = 3'b000;
    if (w_busy) begin
      case (r_word[10:9])
        2'd0:    w_bram_en = 3'b001;
        2'd1:    w_bram_en = 3'b010;
        2'd2:    w_bram_en = 3'b100;
        default: w_bram_en = 3'b000;
      endcase
    end
  end

  assign header_wr_o      = r_header_wr;
  assign header_dat_o     = r_header_dat;
  assign wr_we_o          = clk_ce_i & w_busy;
  assign wr_bram_en_o     = w_bram_en;
  assign wr_bram_addr_o   = r_word[8:0];
  assign wr_buf_o         = r_wr_ptr;
  assign busy_o           = w_busy;
  assign data_available_o = (r_buf_count != '0);
  assign buf_count_o      = r_buf_count;
  assign dropped_o        = r_dropped;
  assign drop_count_o     = r_drop_count;
  assign err_underflow_o  = r_err_underflow;

endmodule

`default_nettype wire

// File: tb/tb_uram_event_write_sm.sv
// Directed self-checking bench for uram_event_write_sm.
`timescale 1ns/1ps

module tb_uram_event_write_sm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        trig = 1'b0;
  logic [31:0] trig_time = '0;
  logic        complete = 1'b0;
  logic        header_wr;
  logic [63:0] header_dat;
  logic        wr_we;
  logic [2:0]  bram_en;
  logic [8:0]  bram_addr;
  logic [1:0]  wr_buf;
  logic        busy;
  logic        data_av;
  logic [2:0]  buf_count;
  logic        dropped;
  logic [15:0] drop_count;
  logic        err_uf;

  int checks = 0;
  int errors = 0;

  uram_event_write_sm #(.NBUF_BITS(2), .HOLDOFF(64)) dut (
    .clk_i(clk), .rst_i(rst), .clk_ce_i(ce), .trig_i(trig), .trig_time_i(trig_time),
    .header_wr_o(header_wr), .header_dat_o(header_dat), .wr_we_o(wr_we),
    .wr_bram_en_o(bram_en), .wr_bram_addr_o(bram_addr), .wr_buf_o(wr_buf),
    .busy_o(busy), .data_available_o(data_av), .complete_i(complete),
    .buf_count_o(buf_count), .dropped_o(dropped), .drop_count_o(drop_count),
    .err_underflow_o(err_uf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; trig = 1'b0; complete = 1'b0; ce = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Single-cycle trigger on a ce cycle.
  task automatic pulse_trig(input logic [31:0] t);
    ce = 1'b1; trig = 1'b1; trig_time = t;
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    ce = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (busy === 1'b0) begin
        timed_out = 1'b0;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; trig = 1'b1; complete = 1'b1; trig_time = 32'hFFFF_FFFF;
    tick(); tick();
    if (header_wr !== 1'b0) begin errors++; $display("FAIL rst_header_wr got %b exp 0", header_wr); end
    checks++;
    if (header_dat !== 64'h0) begin errors++; $display("FAIL rst_header_dat got %h exp 0", header_dat); end
    checks++;
    if (wr_we !== 1'b0 || bram_en !== 3'b000) begin errors++; $display("FAIL rst_we got %b/%b exp 0/000", wr_we, bram_en); end
    checks++;
    if (busy !== 1'b0 || wr_buf !== 2'd0 || bram_addr !== 9'd0) begin
      errors++; $display("FAIL rst_state got busy %b buf %0d addr %0d exp 0 0 0", busy, wr_buf, bram_addr);
    end
    checks++;
    if (buf_count !== 3'd0 || data_av !== 1'b0) begin errors++; $display("FAIL rst_count got %0d/%b exp 0/0", buf_count, data_av); end
    checks++;
    if (dropped !== 1'b0 || drop_count !== 16'd0 || err_uf !== 1'b0) begin
      errors++; $display("FAIL rst_flags got %b %0d %b exp 0 0 0", dropped, drop_count, err_uf);
    end
    checks++;
    rst = 1'b0; complete = 1'b0; trig = 1'b1; ce = 1'b0;
    tick();
    trig = 1'b0;
    if (header_wr !== 1'b0 || busy !== 1'b0 || dropped !== 1'b0) begin
      errors++; $display("FAIL trig_no_ce got hdr %b busy %b drop %b exp 0 0 0", header_wr, busy, dropped);
    end
    checks++;
  endtask

  task automatic test_single_capture();
    int writes = 0;
    int addr_bad = 0;
    int we_bad = 0;
    int hdr_extra = 0;
    logic [2:0] exp_en;
    logic [8:0] exp_addr;
    pulse_trig(32'h1234_5678);
    if (header_wr !== 1'b1 || header_dat !== 64'h0000_0000_1234_5678) begin
      errors++; $display("FAIL header got %b %h exp 1 0000000012345678", header_wr, header_dat);
    end
    checks++;
    if (busy !== 1'b1 || wr_buf !== 2'd0) begin errors++; $display("FAIL cap_start got busy %b buf %0d exp 1 0", busy, wr_buf); end
    checks++;
    for (int i = 0; i < 5000 && writes < 1536; i++) begin
      ce = (i % 2 == 1);
      #1;
      if (wr_we !== ce) we_bad++;
      if (ce) begin
        exp_en = 3'(3'b001 << (writes / 512));
        exp_addr = 9'(writes % 512);
        if (bram_en !== exp_en || bram_addr !== exp_addr) addr_bad++;
      end
      tick();
      if (ce) writes++;
      if (header_wr !== 1'b0) hdr_extra++;
    end
    if (writes != 1536) begin errors++; $display("FAIL write_count got %0d exp 1536", writes); end
    checks++;
    if (we_bad != 0) begin errors++; $display("FAIL we_follows_ce got %0d bad exp 0", we_bad); end
    checks++;
    if (addr_bad != 0) begin errors++; $display("FAIL addr_seq got %0d bad exp 0", addr_bad); end
    checks++;
    if (hdr_extra != 0) begin errors++; $display("FAIL header_once got %0d extra exp 0", hdr_extra); end
    checks++;
    if (busy !== 1'b0 || wr_buf !== 2'd1 || buf_count !== 3'd0 || data_av !== 1'b0) begin
      errors++; $display("FAIL after_last got busy %b buf %0d cnt %0d av %b exp 0 1 0 0", busy, wr_buf, buf_count, data_av);
    end
    checks++;
    ce = 1'b1;
    #1;
    if (wr_we !== 1'b0 || bram_en !== 3'b000) begin errors++; $display("FAIL idle_we got %b/%b exp 0/000", wr_we, bram_en); end
    checks++;
    tick();
    if (buf_count !== 3'd1 || data_av !== 1'b1) begin errors++; $display("FAIL commit got %0d/%b exp 1/1", buf_count, data_av); end
    checks++;
  endtask

  task automatic test_back_to_back();
    bit to;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pulse_trig(32'hA000_0000 + 32'(k));
      if (header_wr !== 1'b1 || header_dat !== {32'(k), 32'hA000_0000 + 32'(k)} || wr_buf !== 2'(k)) begin
        errors++; $display("FAIL b2b_hdr%0d got %b %h buf %0d exp 1 buf %0d", k, header_wr, header_dat, wr_buf, k);
      end
      checks++;
      wait_idle(to);
      if (to) begin errors++; $display("FAIL b2b_timeout%0d got busy %b exp 0", k, busy); end
      checks++;
    end
    pulse_trig(32'hDEAD_BEEF);
    if (dropped !== 1'b1 || header_wr !== 1'b0 || busy !== 1'b0 || drop_count !== 16'd1) begin
      errors++; $display("FAIL fifth_drop got drop %b hdr %b busy %b cnt %0d exp 1 0 0 1", dropped, header_wr, busy, drop_count);
    end
    checks++;
    if (buf_count !== 3'd4 || wr_buf !== 2'd0) begin errors++; $display("FAIL full_count got %0d buf %0d exp 4 0", buf_count, wr_buf); end
    checks++;
    tick();
    if (dropped !== 1'b0 || data_av !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b av %b exp 0 1", dropped, data_av); end
    checks++;
  endtask

  task automatic test_complete_same_clock();
    bit to;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      pulse_trig(32'(k));
      wait_idle(to);
    end
    tick();
    if (buf_count !== 3'd2) begin errors++; $display("FAIL pre_count got %0d exp 2", buf_count); end
    checks++;
    pulse_trig(32'h5);
    wait_idle(to);
    if (to) begin errors++; $display("FAIL cc_timeout got busy %b exp 0", busy); end
    checks++;
    complete = 1'b1;
    tick();
    complete = 1'b0;
    if (buf_count !== 3'd2) begin errors++; $display("FAIL same_clock got %0d exp 2", buf_count); end
    checks++;
    complete = 1'b1;
    tick();
    complete = 1'b0;
    if (buf_count !== 3'd1 || err_uf !== 1'b0) begin errors++; $display("FAIL decrement got %0d uf %b exp 1 0", buf_count, err_uf); end
    checks++;
  endtask

  task automatic test_underflow();
    do_reset();
    complete = 1'b1;
    tick();
    complete = 1'b0;
    if (buf_count !== 3'd0 || err_uf !== 1'b1) begin errors++; $display("FAIL underflow got %0d uf %b exp 0 1", buf_count, err_uf); end
    checks++;
    tick(); tick(); tick();
    if (err_uf !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", err_uf); end
    checks++;
    do_reset();
    if (err_uf !== 1'b0) begin errors++; $display("FAIL uf_clear got %b exp 0", err_uf); end
    checks++;
  endtask

  task automatic test_reset_mid_capture();
    bit to;
    do_reset();
    pulse_trig(32'h1111_1111);
    wait_idle(to);
    pulse_trig(32'h2222_2222);
    if (header_dat !== {32'd1, 32'h2222_2222} || wr_buf !== 2'd1) begin
      errors++; $display("FAIL second_hdr got %h buf %0d exp 0000000122222222 1", header_dat, wr_buf);
    end
    checks++;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    if (dropped !== 1'b1 || drop_count !== 16'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL retrig_drop got %b %0d busy %b exp 1 1 1", dropped, drop_count, busy);
    end
    checks++;
    for (int i = 0; i < 699; i++) tick();
    #1;
    if (wr_we !== 1'b1 || bram_en !== 3'b010 || bram_addr !== 9'd188) begin
      errors++; $display("FAIL word700 got %b %b %0d exp 1 010 188", wr_we, bram_en, bram_addr);
    end
    checks++;
    rst = 1'b1;
    tick();
    if (busy !== 1'b0 || wr_we !== 1'b0 || buf_count !== 3'd0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL mid_reset got busy %b we %b cnt %0d drops %0d exp 0 0 0 0", busy, wr_we, buf_count, drop_count);
    end
    checks++;
    rst = 1'b0;
    tick(); tick();
    if (buf_count !== 3'd0 || data_av !== 1'b0) begin errors++; $display("FAIL no_commit got %0d/%b exp 0/0", buf_count, data_av); end
    checks++;
    pulse_trig(32'hCAFE_F00D);
    if (header_wr !== 1'b1 || header_dat !== {32'd0, 32'hCAFE_F00D} || wr_buf !== 2'd0) begin
      errors++; $display("FAIL post_reset_hdr got %b %h buf %0d exp 1 00000000cafef00d 0", header_wr, header_dat, wr_buf);
    end
    checks++;
    wait_idle(to);
  endtask

`ifdef URAM_EVENT_WRITE_HOLDOFF_EN
  task automatic test_holdoff();
    bit to;
    do_reset();
    pulse_trig(32'h0);
    wait_idle(to);
    for (int i = 1; i < 10; i++) tick();
    pulse_trig(32'h10);
    if (dropped !== 1'b1 || header_wr !== 1'b0 || drop_count !== 16'd1) begin
      errors++; $display("FAIL holdoff_drop got %b %b %0d exp 1 0 1", dropped, header_wr, drop_count);
    end
    checks++;
    for (int i = 11; i < 65; i++) tick();
    pulse_trig(32'h65);
    if (header_wr !== 1'b1 || dropped !== 1'b0) begin
      errors++; $display("FAIL holdoff_accept got hdr %b drop %b exp 1 0", header_wr, dropped);
    end
    checks++;
    wait_idle(to);
  endtask
`endif

  initial begin
    test_reset();
    test_single_capture();
    test_back_to_back();
    test_complete_same_clock();
    test_underflow();
    test_reset_mid_capture();
`ifdef URAM_EVENT_WRITE_HOLDOFF_EN
    test_holdoff();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
